hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller that sits beside the forwarding unit in the 5-stage MIPS core.
- Detects load-use hazards that forwarding cannot cover, and stalls IF/ID while injecting a bubble into ID/EX.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Holds the front end for a fixed number of cycles while the multi-cycle mult/div unit is busy; keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/hazard_stall_controller_sat_counter.sv | 20 ++
 rtl/hazard_stall_controller.sv | 113 +++++++++++
 tb/tb_hazard_stall_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencing states, opcode constants,
// the NOP encoding and the load-use hazard predicate.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    // $zero is never a real producer, so a load into r0 cannot create a hazard.
    function automatic logic load_use(
        input logic [5:0] ex_opcode,
        input logic [5:0] lw_opcode,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return (ex_opcode == lw_opcode) && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter used for the performance-debug statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying edges, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use stall, branch flush and mult/div hold sequencing for the 5-stage
// pipeline, with saturating stall/flush statistics.
module hazard_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter logic [5:0] LW_OPCODE      = OP_LW,
    parameter int         MULDIV_LATENCY = 4,
    parameter int         CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_uses_Rt,
    input  logic             ID_muldiv_start,
    input  logic [4:0]       EX_Rt,
    input  logic [5:0]       EX_opcode,
    input  logic             EX_branch_taken,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W   = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;
    localparam int LOAD_VAL = (MULDIV_LATENCY > 1) ? (MULDIV_LATENCY - 2) : 0;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LOAD_VAL);
    localparam logic              MULTI_CYCLE = (MULDIV_LATENCY > 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu;

    assign lu = load_use(EX_opcode, LW_OPCODE, EX_Rt, ID_Rs, ID_Rt, ID_uses_Rt);

    // Pipeline enables as a function of state and current hazards.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        muldiv_busy = 1'b0;
        case (state)
            RUN: begin
                if (EX_branch_taken) begin
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                end else if (lu) begin
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                end else begin
                    PC_Write    = 1'b1;
                end
            end
            MULDIV: begin
                PC_Write    = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                muldiv_busy = 1'b1;
            end
            default: begin
                PC_Write    = 1'b1;
            end
        endcase
    end

    // Sequencing FSM; a squashed or stalled ID instruction never starts mult/div.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= {WAIT_W{1'b0}};
        end else begin
            case (state)
                RUN: begin
                    if (!EX_branch_taken && !lu && ID_muldiv_start && MULTI_CYCLE) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= MULDIV;
                    end
                end
                MULDIV: begin
                    if (wait_cnt == {WAIT_W{1'b0}}) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~PC_Write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (IFID_Flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: vector table for single-cycle decisions plus hand-written
// sequences for mult/div hold, async reset and counter saturation.
module tb_hazard_stall_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
    logic          ID_uses_Rt, ID_muldiv_start, EX_branch_taken;
    logic [5:0]    EX_opcode;
    logic          PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, muldiv_busy;
    logic [CW-1:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .LW_OPCODE      (6'b100011),
        .MULDIV_LATENCY (4),
        .CNT_W          (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_Rs           (ID_Rs),
        .ID_Rt           (ID_Rt),
        .ID_uses_Rt      (ID_uses_Rt),
        .ID_muldiv_start (ID_muldiv_start),
        .EX_Rt           (EX_Rt),
        .EX_opcode       (EX_opcode),
        .EX_branch_taken (EX_branch_taken),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .IFID_Flush      (IFID_Flush),
        .IDEX_Bubble     (IDEX_Bubble),
        .muldiv_busy     (muldiv_busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, muldiv_busy}
    localparam logic [4:0] O_RUN    = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00010;
    localparam logic [4:0] O_FLUSH  = 5'b11110;
    localparam logic [4:0] O_MULDIV = 5'b00011;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, ex_rt;
        logic       uses_rt, mstart, br;
        logic [5:0] op;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [4:0] outs();
        return {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, muldiv_busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mstart, input logic [4:0] ex_rt, input logic [5:0] op,
                         input logic br);
        ID_Rs = rs; ID_Rt = rt; ID_uses_Rt = uses_rt; ID_muldiv_start = mstart;
        EX_Rt = ex_rt; EX_opcode = op; EX_branch_taken = br;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        vecs[0] = '{"idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, O_RUN};
        vecs[1] = '{"lu_rs",       5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 6'b100011, O_STALL};
        vecs[2] = '{"rt_unused",   5'd1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 6'b100011, O_RUN};
        vecs[3] = '{"rt_used",     5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 6'b100011, O_STALL};
        vecs[4] = '{"zero_reg",    5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'b100011, O_RUN};
        vecs[5] = '{"store_no_lu", 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 6'b101011, O_RUN};
        vecs[6] = '{"branch_prio", 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 6'b100011, O_FLUSH};
        vecs[7] = '{"lu_rs_alt",   5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 6'b100011, O_STALL};

        #1;
        check("reset_outs", 32'(outs()), 32'(O_RUN));
        check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        check("reset_flush_cnt", 32'(flush_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mstart,
                  vecs[i].ex_rt, vecs[i].op, vecs[i].br);
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            @(negedge clk);
        end
        idle();
        #1;
        check("branch_no_muldiv", 32'(outs()), 32'(O_RUN));
        check("table_stall_cnt", 32'(stall_cycles), 32'd3);
        check("table_flush_cnt", 32'(flush_count), 32'd1);

        // Single load-use stall then release.
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 6'b100011, 1'b0);
        #1 check("seq_lu_stall", 32'(outs()), 32'(O_STALL));
        @(negedge clk);
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 6'b000000, 1'b0);
        #1 check("seq_lu_release", 32'(outs()), 32'(O_RUN));
        check("seq_lu_stall_cnt", 32'(stall_cycles), 32'd1);

        // Mult/div: one issue cycle, three held cycles; branch ignored while held.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 6'd0, 1'b0);
        #1 check("md_issue", 32'(outs()), 32'(O_RUN));
        @(negedge clk);
        drive(5'd2, 5'd0, 1'b0, 1'b0, 5'd2, 6'b100011, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("md_wait%0d", c), 32'(outs()), 32'(O_MULDIV));
            @(negedge clk);
        end
        idle();
        #1 check("md_done", 32'(outs()), 32'(O_RUN));
        check("md_stall_cnt", 32'(stall_cycles), 32'd3);
        check("md_flush_cnt", 32'(flush_count), 32'd0);

        // Async reset in the second wait cycle.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 6'd0, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1 check("rst_pre_busy", 32'(muldiv_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_outs", 32'(outs()), 32'(O_RUN));
        check("rst_async_stall_cnt", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1 check("rst_after_run", 32'(outs()), 32'(O_RUN));

        // Saturation: 20 consecutive load-use stalls on a 4-bit counter.
        do_reset();
        drive(5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 6'b100011, 1'b0);
        for (int c = 0; c < 20; c++) @(negedge clk);
        #1 check("sat_stall_cnt", 32'(stall_cycles), 32'd15);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
